// File: rtl/rv32_dbus_ahb_master.sv
// rv32 data-port to AHB-Lite master: one NONSEQ SINGLE transfer per accepted request.
// Optional posted writes when DBUS_POSTED_WRITE_EN is defined.
module rv32_dbus_ahb_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [3:0]  HPROT_DATA = 4'b0001
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  core_req_in,
  input  logic                  core_we_in,
  input  logic [ADDR_WIDTH-1:0] core_addr_in,
  input  logic [31:0]           core_wdata_in,
  input  logic [3:0]            core_wmask_in,
  output logic [31:0]           core_rdata_out,
  output logic                  core_ready_out,
  output logic                  core_err_out,
  output logic [ADDR_WIDTH-1:0] haddr_out,
  output logic [1:0]            htrans_out,
  output logic                  hwrite_out,
  output logic [2:0]            hsize_out,
  output logic [2:0]            hburst_out,
  output logic [3:0]            hprot_out,
  output logic [31:0]           hwdata_out,
  input  logic [31:0]           hrdata_in,
  input  logic                  hready_in,
  input  logic                  hresp_in,
  output logic                  wr_err_sticky_out
);

`ifdef DBUS_POSTED_WRITE_EN
  localparam logic POSTED_EN = 1'b1;
`else
  localparam logic POSTED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  posted_q, posted_d;
  logic                  sticky_q, sticky_d;
  logic                  ready_q, ready_d;
  logic                  resp_err_q, resp_err_d;

  logic [2:0]            dec_size;
  logic [1:0]            dec_lo;
  logic                  dec_legal;
  logic                  posted_ack;
  logic                  unused_addr_lo;

  // Low address bits come from the lane mask (writes) or are forced to 0 (reads).
  assign unused_addr_lo = ^core_addr_in[1:0];

  always_comb begin
    dec_size  = 3'b010;
    dec_lo    = 2'b00;
    dec_legal = 1'b1;
    if (core_we_in) begin
      case (core_wmask_in)
        4'b1111: begin dec_size = 3'b010; dec_lo = 2'b00; end
        4'b0011: begin dec_size = 3'b001; dec_lo = 2'b00; end
        4'b1100: begin dec_size = 3'b001; dec_lo = 2'b10; end
        4'b0001: begin dec_size = 3'b000; dec_lo = 2'b00; end
        4'b0010: begin dec_size = 3'b000; dec_lo = 2'b01; end
        4'b0100: begin dec_size = 3'b000; dec_lo = 2'b10; end
        4'b1000: begin dec_size = 3'b000; dec_lo = 2'b11; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign posted_ack = (state_q == S_IDLE) && core_req_in && core_we_in && dec_legal && POSTED_EN;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    posted_d = posted_q;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_in) begin
          write_d = core_we_in;
          wdata_d = core_wdata_in;
          size_d  = dec_size;
          addr_d  = {core_addr_in[ADDR_WIDTH-1:2], dec_lo};
          if (!dec_legal) begin
            state_d  = S_RESP;
            err_d    = 1'b1;
            posted_d = 1'b0;
          end else begin
            state_d  = S_ADDR;
            err_d    = 1'b0;
            posted_d = POSTED_EN && core_we_in;
          end
        end
      end
      S_ADDR: begin
        if (hready_in) state_d = S_DATA;
      end
      S_DATA: begin
        // hresp_in with hready_in low is the first ERROR cycle: just keep waiting.
        if (hready_in) begin
          rdata_d = hrdata_in;
          err_d   = hresp_in;
          if (posted_q) begin
            state_d  = S_IDLE;
            sticky_d = sticky_q || hresp_in;
          end else begin
            state_d  = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d    = (state_d == S_RESP) || posted_ack;
    resp_err_d = (state_d == S_RESP) && err_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 3'b000;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      posted_q   <= 1'b0;
      sticky_q   <= 1'b0;
      ready_q    <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      posted_q   <= posted_d;
      sticky_q   <= sticky_d;
      ready_q    <= ready_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign htrans_out        = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign haddr_out         = addr_q;
  assign hwrite_out        = write_q;
  assign hsize_out         = size_q;
  assign hburst_out        = 3'b000;
  assign hprot_out         = HPROT_DATA;
  assign hwdata_out        = wdata_q;
  assign core_rdata_out    = rdata_q;
  assign core_ready_out    = ready_q;
  assign core_err_out      = resp_err_q;
  assign wr_err_sticky_out = sticky_q;

endmodule

// File: tb/tb_rv32_dbus_ahb_master.sv
// Directed bench for rv32_dbus_ahb_master: transaction-level model plus per-cycle compare
// and literal latency/address checks. Honours DBUS_POSTED_WRITE_EN if defined.
module tb_rv32_dbus_ahb_master;

`ifdef DBUS_POSTED_WRITE_EN
  localparam bit POSTED  = 1'b1;
  localparam int WR_LAT0 = 1;
  localparam int WR_LAT1 = 1;
`else
  localparam bit POSTED  = 1'b0;
  localparam int WR_LAT0 = 3;
  localparam int WR_LAT1 = 4;
`endif
  localparam int MAXC = 256;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        core_req_in = 1'b0, core_we_in = 1'b0;
  logic [31:0] core_addr_in = '0, core_wdata_in = '0;
  logic [3:0]  core_wmask_in = '0;
  logic [31:0] core_rdata_out;
  logic        core_ready_out, core_err_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out, hburst_out;
  logic [3:0]  hprot_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in = '0;
  logic        hready_in = 1'b1, hresp_in = 1'b0;
  logic        wr_err_sticky_out;

  rv32_dbus_ahb_master #(.ADDR_WIDTH(32), .HPROT_DATA(4'b0001)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .core_req_in(core_req_in), .core_we_in(core_we_in), .core_addr_in(core_addr_in),
    .core_wdata_in(core_wdata_in), .core_wmask_in(core_wmask_in),
    .core_rdata_out(core_rdata_out), .core_ready_out(core_ready_out), .core_err_out(core_err_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out), .hsize_out(hsize_out),
    .hburst_out(hburst_out), .hprot_out(hprot_out), .hwdata_out(hwdata_out),
    .hrdata_in(hrdata_in), .hready_in(hready_in), .hresp_in(hresp_in),
    .wr_err_sticky_out(wr_err_sticky_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Expected per-cycle behaviour, filled in by the transaction model.
  logic [1:0]  e_htrans [MAXC];
  bit          e_ready  [MAXC];
  bit          e_err    [MAXC];
  bit          e_rdchk  [MAXC];
  bit          e_hwchk  [MAXC];
  logic [31:0] e_addr   [MAXC];
  logic [31:0] e_rdata  [MAXC];
  logic [31:0] e_wdata  [MAXC];
  logic [2:0]  e_size   [MAXC];
  logic        e_write  [MAXC];
  int          sticky_from = MAXC + 1;

  function automatic void model_decode(input logic we, input logic [3:0] m, input logic [31:0] a,
                                       output bit legal, output logic [2:0] sz, output logic [31:0] ha);
    int n = 0;
    int lo = 0;
    bit seen = 0;
    for (int i = 0; i < 4; i++) if (m[i]) begin
      n++;
      if (!seen) begin lo = i; seen = 1; end
    end
    if (!we) begin
      legal = 1; sz = 3'd2; ha = {a[31:2], 2'b00};
      return;
    end
    legal = (n == 4) || (n == 1) || (n == 2 && (m == 4'b0011 || m == 4'b1100));
    sz    = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    ha    = legal ? ({a[31:2], 2'b00} + 32'(lo)) : a;
  endfunction

  // s = edge index at which the request is sampled (cycle s is the first cycle after capture).
  task automatic expect_txn(input int s, input logic we, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] wd, input int waits, input bit er, input logic [31:0] rd);
    bit legal; logic [2:0] sz; logic [31:0] ha; int len;
    model_decode(we, m, a, legal, sz, ha);
    if (!legal) begin
      e_ready[s] = 1; e_err[s] = 1;
      return;
    end
    len = waits + (er ? 2 : 1);
    e_htrans[s] = 2'b10; e_addr[s] = ha; e_size[s] = sz; e_write[s] = we;
    for (int k = 1; k <= len; k++) begin e_hwchk[s+k] = we; e_wdata[s+k] = wd; end
    if (POSTED && we) begin
      e_ready[s] = 1;
      if (er && (s + len + 1) < sticky_from) sticky_from = s + len + 1;
    end else begin
      e_ready[s+len+1] = 1; e_err[s+len+1] = er;
      e_rdchk[s+len+1] = !we && !er; e_rdata[s+len+1] = rd;
    end
  endtask

  always @(negedge clk_in) begin
    if (cyc < MAXC) begin
      check("htrans", 32'(htrans_out), 32'(e_htrans[cyc]));
      check("ready", 32'(core_ready_out), 32'(e_ready[cyc]));
      check("err", 32'(core_err_out), 32'(e_err[cyc]));
      check("sticky", 32'(wr_err_sticky_out), 32'(cyc >= sticky_from));
      if (e_htrans[cyc] == 2'b10) begin
        check("haddr", haddr_out, e_addr[cyc]);
        check("hsize", 32'(hsize_out), 32'(e_size[cyc]));
        check("hwrite", 32'(hwrite_out), 32'(e_write[cyc]));
        check("hburst", 32'(hburst_out), 32'h0);
        check("hprot", 32'(hprot_out), 32'h1);
      end
      if (e_hwchk[cyc]) check("hwdata", hwdata_out, e_wdata[cyc]);
      if (e_rdchk[cyc]) check("rdata", core_rdata_out, e_rdata[cyc]);
    end
  end

  // Observed completions / address phases, for literal checks.
  int          rq_cyc[$];
  logic        rq_err[$];
  logic [31:0] rq_data[$];
  logic [31:0] aq_addr[$];
  logic [2:0]  aq_size[$];
  always @(negedge clk_in) begin
    if (core_ready_out === 1'b1) begin
      rq_cyc.push_back(cyc); rq_err.push_back(core_err_out); rq_data.push_back(core_rdata_out);
    end
    if (htrans_out === 2'b10) begin aq_addr.push_back(haddr_out); aq_size.push_back(hsize_out); end
  end

  task automatic lit_ready(input string nm, input int c_req, input int delta, input bit er,
                           input bit chk_data, input logic [31:0] d);
    int c; logic e; logic [31:0] x;
    if (rq_cyc.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_pulse actual=none required=pulse", nm);
    end else begin
      c = rq_cyc.pop_front(); e = rq_err.pop_front(); x = rq_data.pop_front();
      check({nm, "_lat"}, 32'(c - c_req), 32'(delta));
      check({nm, "_err"}, 32'(e), 32'(er));
      if (chk_data) check({nm, "_rdata"}, x, d);
      check({nm, "_once"}, 32'(rq_cyc.size()), 32'h0);
    end
  endtask

  task automatic lit_addr(input string nm, input logic [31:0] a, input logic [2:0] sz);
    if (aq_addr.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_nonseq actual=none required=%0h", nm, a);
    end else begin
      check({nm, "_haddr"}, aq_addr.pop_front(), a);
      check({nm, "_hsize"}, 32'(aq_size.pop_front()), 32'(sz));
      check({nm, "_nonseq_once"}, 32'(aq_addr.size()), 32'h0);
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd,
                         input int waits, input bit er, input logic [31:0] rd, output int c_req);
    bit legal; logic [2:0] sz; logic [31:0] ha;
    @(posedge clk_in); #1;
    c_req = cyc;
    expect_txn(cyc + 1, we, a, m, wd, waits, er, rd);
    core_req_in = 1; core_we_in = we; core_addr_in = a; core_wdata_in = wd; core_wmask_in = m;
    @(posedge clk_in); #1;
    core_req_in = 0; core_we_in = ~we; core_addr_in = ~a; core_wdata_in = ~wd; core_wmask_in = ~m;
    hready_in = 1; hresp_in = 0; hrdata_in = 32'h0;
    model_decode(we, m, a, legal, sz, ha);
    if (legal) begin
      repeat (waits) begin @(posedge clk_in); #1; hready_in = 0; hresp_in = 0; end
      @(posedge clk_in); #1;
      if (er) begin
        hready_in = 0; hresp_in = 1;
        @(posedge clk_in); #1;
        hready_in = 1; hresp_in = 1; hrdata_in = rd;
      end else begin
        hready_in = 1; hresp_in = 0; hrdata_in = rd;
      end
      @(posedge clk_in); #1;
      hready_in = 1; hresp_in = 0; hrdata_in = 32'h0;
    end
    @(posedge clk_in); #1;
  endtask

  initial begin
    int c;
    for (int k = 0; k < MAXC; k++) begin
      e_htrans[k] = 2'b00; e_addr[k] = '0; e_rdata[k] = '0; e_wdata[k] = '0; e_size[k] = '0; e_write[k] = 0;
    end
    #2;
    check("rst_htrans", 32'(htrans_out), 32'h0);
    check("rst_haddr", haddr_out, 32'h0);
    check("rst_hwrite", 32'(hwrite_out), 32'h0);
    check("rst_hsize", 32'(hsize_out), 32'h0);
    check("rst_hwdata", hwdata_out, 32'h0);
    check("rst_rdata", core_rdata_out, 32'h0);
    check("rst_ready", 32'(core_ready_out), 32'h0);
    check("rst_sticky", 32'(wr_err_sticky_out), 32'h0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1;

    run_txn(0, 32'h0000_1004, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, c);
    lit_addr("rd1004", 32'h0000_1004, 3'b010);
    lit_ready("rd1004", c, 3, 0, 1, 32'hDEAD_BEEF);

    run_txn(1, 32'h0000_2003, 4'b1000, 32'hAB00_0000, 0, 0, 32'h0, c);
    lit_addr("wrb", 32'h0000_2003, 3'b000);
    lit_ready("wrb", c, WR_LAT0, 0, 0, 32'h0);

    run_txn(1, 32'h0000_3002, 4'b1111, 32'h1234_5678, 1, 0, 32'h0, c);
    lit_addr("wrw", 32'h0000_3000, 3'b010);
    lit_ready("wrw", c, WR_LAT1, 0, 0, 32'h0);

    run_txn(1, 32'h0000_4001, 4'b1100, 32'h5A5A_0000, 0, 0, 32'h0, c);
    lit_addr("wrh", 32'h0000_4002, 3'b001);
    lit_ready("wrh", c, WR_LAT0, 0, 0, 32'h0);

    run_txn(1, 32'h0000_2100, 4'b0101, 32'h0101_0101, 0, 0, 32'h0, c);
    check("ill0101_nonseq", 32'(aq_addr.size()), 32'h0);
    lit_ready("ill0101", c, 1, 1, 0, 32'h0);

    run_txn(1, 32'h0000_2200, 4'b0000, 32'h0, 0, 0, 32'h0, c);
    check("ill0000_nonseq", 32'(aq_addr.size()), 32'h0);
    lit_ready("ill0000", c, 1, 1, 0, 32'h0);

    run_txn(1, 32'h0000_2300, 4'b0110, 32'h0, 0, 0, 32'h0, c);
    check("ill0110_nonseq", 32'(aq_addr.size()), 32'h0);
    lit_ready("ill0110", c, 1, 1, 0, 32'h0);

    run_txn(0, 32'h0000_5007, 4'h0, 32'h0, 2, 1, 32'h7777_7777, c);
    lit_addr("rderr", 32'h0000_5004, 3'b010);
    lit_ready("rderr", c, 6, 1, 0, 32'h0);

    run_txn(0, 32'h0000_6000, 4'h0, 32'h0, 1, 0, 32'h0BAD_F00D, c);
    lit_addr("rdws", 32'h0000_6000, 3'b010);
    lit_ready("rdws", c, 4, 0, 1, 32'h0BAD_F00D);

    // Reset asserted during the data phase of a read.
    @(posedge clk_in); #1;
    c = cyc;
    expect_txn(c + 1, 0, 32'h0000_7008, 4'h0, 32'h0, 3, 0, 32'h1111_1111);
    for (int k = c + 2; k < c + 14; k++) begin e_ready[k] = 0; e_err[k] = 0; e_rdchk[k] = 0; e_htrans[k] = 2'b00; end
    core_req_in = 1; core_we_in = 0; core_addr_in = 32'h0000_7008;
    @(posedge clk_in); #1;
    core_req_in = 0; hready_in = 1;
    @(posedge clk_in); #1;
    hready_in = 0;
    #2 rst_in = 0;
    #1;
    check("midrst_htrans", 32'(htrans_out), 32'h0);
    check("midrst_haddr", haddr_out, 32'h0);
    check("midrst_ready", 32'(core_ready_out), 32'h0);
    check("midrst_hwrite", 32'(hwrite_out), 32'h0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1; hready_in = 1;
    lit_addr("midrst", 32'h0000_7008, 3'b010);
    check("midrst_no_ready", 32'(rq_cyc.size()), 32'h0);

    run_txn(0, 32'h0000_00FC, 4'h0, 32'h0, 0, 0, 32'hCAFE_F00D, c);
    lit_addr("postrst", 32'h0000_00FC, 3'b010);
    lit_ready("postrst", c, 3, 0, 1, 32'hCAFE_F00D);

`ifdef DBUS_POSTED_WRITE_EN
    run_txn(1, 32'h0000_8000, 4'b1111, 32'hFEED_0001, 0, 1, 32'h0, c);
    lit_addr("pwerr", 32'h0000_8000, 3'b010);
    lit_ready("pwerr", c, 1, 0, 0, 32'h0);
    @(posedge clk_in); #1;
    check("pwerr_sticky", 32'(wr_err_sticky_out), 32'h1);
`else
    run_txn(1, 32'h0000_8000, 4'b1111, 32'hFEED_0001, 0, 1, 32'h0, c);
    lit_addr("wrerr", 32'h0000_8000, 3'b010);
    lit_ready("wrerr", c, 4, 1, 0, 32'h0);
    @(posedge clk_in); #1;
    check("wrerr_sticky", 32'(wr_err_sticky_out), 32'h0);
`endif

    repeat (3) @(posedge clk_in);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
